// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_pkg
// Brief    : Shared pipeline constants and writeback-select helpers.
// Revision : 1.0 - initial release
// ============================================================================
package wb_regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    // Bit positions inside the MEM/WB in_ctl field
    localparam int WB_CTL_MEMTOREG = 2;
    localparam int WB_CTL_REGWRITE = 1;
    localparam int WB_CTL_JAL      = 0;
    localparam int WB_CTL_W        = 3;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MEM = 2'd1,
        WB_SRC_PC  = 2'd2
    } wb_src_e;

    // Link write beats a load: a jal never carries valid load data
    function automatic wb_src_e wb_src_sel(input logic mem_to_reg, input logic jal);
        wb_src_e src;
        src = WB_SRC_ALU;
        if (jal) begin
            src = WB_SRC_PC;
        end else if (mem_to_reg) begin
            src = WB_SRC_MEM;
        end
        return src;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_regfile_mux.sv
`default_nettype none
// ============================================================================
// Module   : wb_mux
// Brief    : Combinational 3:1 writeback value select (PC / load / ALU).
// Revision : 1.0 - initial release
// ============================================================================
module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = wb_regfile_pkg::DATA_W
) (
    input  logic              mem_to_reg,
    input  logic              jal,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] wb_data
);

    wb_src_e w_src;

    assign w_src = wb_src_sel(mem_to_reg, jal);

    always_comb begin
        wb_data = alu_out;
        case (w_src)
            WB_SRC_PC:  wb_data = pc;
            WB_SRC_MEM: wb_data = dmem_rdata;
            default:    wb_data = alu_out;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Brief    : Writeback select plus 32x32 register file with write-through bypass.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_regfile_pkg::ADDR_W,
    parameter int NREGS  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              Jal,
    input  logic [ADDR_W-1:0] wn,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] pc,
    input  logic [ADDR_W-1:0] rn1,
    input  logic [ADDR_W-1:0] rn2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_valid
);

    localparam logic [ADDR_W-1:0] c_reg_zero = ADDR_W'(REG_ZERO);

    // r0 has no storage; it is hard-wired to zero at the read ports
    logic [DATA_W-1:0] r_regs [1:NREGS-1];

    wb_mux #(
        .DATA_W (DATA_W)
    ) u_wb_mux (
        .mem_to_reg (MemtoReg),
        .jal        (Jal),
        .dmem_rdata (dmem_rdata),
        .alu_out    (alu_out),
        .pc         (pc),
        .wb_data    (wb_data)
    );

    assign wb_valid = RegWrite && (wn != c_reg_zero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_valid) begin
            r_regs[wn] <= wb_data;
        end
    end

    // Reads return zero while in reset; bypass only applies outside reset
    always_comb begin
        rd1 = '0;
        if (!rst && (rn1 != c_reg_zero)) begin
            if (wb_valid && (wn == rn1)) begin
                rd1 = wb_data;
            end else begin
                rd1 = r_regs[rn1];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (!rst && (rn2 != c_reg_zero)) begin
            if (wb_valid && (wn == rn2)) begin
                rd2 = wb_data;
            end else begin
                rd2 = r_regs[rn2];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Directed plus randomized scoreboard bench for wb_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          RegWrite, MemtoReg, Jal;
    logic [AW-1:0] wn, rn1, rn2;
    logic [DW-1:0] dmem_rdata, alu_out, pc;
    logic [DW-1:0] rd1, rd2, wb_data;
    logic          wb_valid;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q [$];
    string         tag_q [$];
    logic [DW-1:0] model [32];

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .Jal        (Jal),
        .wn         (wn),
        .dmem_rdata (dmem_rdata),
        .alu_out    (alu_out),
        .pc         (pc),
        .rn1        (rn1),
        .rn2        (rn2),
        .rd1        (rd1),
        .rd2        (rd2),
        .wb_data    (wb_data),
        .wb_valid   (wb_valid)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [DW-1:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(input logic [DW-1:0] obs);
        logic [DW-1:0] e;
        string         t;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic jl,
                         input logic [AW-1:0] w, input logic [DW-1:0] dm,
                         input logic [DW-1:0] alu, input logic [DW-1:0] p);
        RegWrite   = rw;
        MemtoReg   = m2r;
        Jal        = jl;
        wn         = w;
        dmem_rdata = dm;
        alu_out    = alu;
        pc         = p;
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] rn, input logic v,
                                               input logic [AW-1:0] w, input logic [DW-1:0] d);
        if (rn == 0) return '0;
        if (v && (w == rn)) return d;
        return model[rn];
    endfunction

    initial begin
        logic          r_rw, r_m2r, r_jal, r_ev;
        logic [DW-1:0] r_ew;

        rst = 1'b1;
        rn1 = 5'd5;
        rn2 = 5'd31;
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);

        // Reset state, and writeback outputs stay live while rst is high
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 5'd3, 32'h0, 32'h55, 32'h0);
        rn1 = 5'd3;
        expect_val("reset_rd1", 32'h0);
        expect_val("reset_rd2", 32'h0);
        expect_val("reset_wb_data", 32'h55);
        expect_val("reset_wb_valid", 32'h1);
        #1;
        check(rd1); check(rd2); check(wb_data); check({31'b0, wb_valid});

        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
        expect_val("write_lost_in_reset", 32'h0);
        #1;
        check(rd1);

        // r5 = DEADBEEF, then async reset between edges
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 5'd5, '0, 32'hDEADBEEF, '0);
        rn1 = 5'd5;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
        expect_val("r5_written", 32'hDEADBEEF);
        #1;
        check(rd1);
        #1;
        rst = 1'b1;
        expect_val("async_reset_clear", 32'h0);
        #1;
        check(rd1);
        @(negedge clk);
        rst = 1'b0;
        expect_val("r5_after_reset", 32'h0);
        #1;
        check(rd1);

        // ALU writeback with bypass then storage
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 5'd8, 32'hBAD0BAD0, 32'h123, 32'h44);
        rn1 = 5'd8;
        expect_val("alu_bypass_rd1", 32'h123);
        expect_val("alu_wb_valid", 32'h1);
        #1;
        check(rd1); check({31'b0, wb_valid});
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd8, '0, 32'h999, '0);
        expect_val("alu_stored_rd1", 32'h123);
        #1;
        check(rd1);

        // Load, then link with MemtoReg also set
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'hCAFEF00D, 32'h1111, 32'h2222);
        expect_val("load_wb_data", 32'hCAFEF00D);
        #1;
        check(wb_data);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 5'd31, 32'h3333, 32'h4444, 32'h00400008);
        expect_val("jal_wb_data", 32'h00400008);
        #1;
        check(wb_data);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
        rn1 = 5'd9;
        rn2 = 5'd31;
        expect_val("r9_load", 32'hCAFEF00D);
        expect_val("r31_link", 32'h00400008);
        #1;
        check(rd1); check(rd2);

        // r0 protection
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 5'd0, '0, 32'hFFFFFFFF, '0);
        rn1 = 5'd0;
        expect_val("r0_wb_valid", 32'h0);
        expect_val("r0_rd1_before", 32'h0);
        #1;
        check({31'b0, wb_valid}); check(rd1);
        @(negedge clk);
        expect_val("r0_rd1_after", 32'h0);
        #1;
        check(rd1);

        // Dual-port bypass over an older value
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 5'd12, '0, 32'h11, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
        rn1 = 5'd12;
        rn2 = 5'd12;
        expect_val("r12_old", 32'h11);
        #1;
        check(rd1);
        drive(1'b1, 1'b0, 1'b0, 5'd12, '0, 32'hA5A5A5A5, '0);
        expect_val("dual_bypass_rd1", 32'hA5A5A5A5);
        expect_val("dual_bypass_rd2", 32'hA5A5A5A5);
        #1;
        check(rd1); check(rd2);

        // Write disabled for three edges
        @(negedge clk);
        rn1 = 5'd4;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, i[0], i[1], 5'd4, 32'h66, 32'h77, 32'h88);
            expect_val("nowrite_wb_valid", 32'h0);
            #1;
            check({31'b0, wb_valid});
            @(negedge clk);
        end
        expect_val("nowrite_r4", 32'h0);
        #1;
        check(rd1);

        // Randomized phase against a reference model, starting from reset
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int it = 0; it < 30; it++) begin
            @(negedge clk);
            r_rw  = ($urandom_range(0, 3) != 0);
            r_m2r = $urandom_range(0, 1) == 1;
            r_jal = ($urandom_range(0, 4) == 0);
            drive(r_rw, r_m2r, r_jal, AW'($urandom_range(0, 31)),
                  $urandom(), $urandom(), $urandom());
            rn1 = (it % 3 == 0) ? wn : AW'($urandom_range(0, 31));
            rn2 = (it % 4 == 1) ? wn : AW'($urandom_range(0, 31));
            r_ew = r_jal ? pc : (r_m2r ? dmem_rdata : alu_out);
            r_ev = r_rw && (wn != 0);
            expect_val("rand_wb_data", r_ew);
            expect_val("rand_wb_valid", {31'b0, r_ev});
            expect_val("rand_rd1", model_rd(rn1, r_ev, wn, r_ew));
            expect_val("rand_rd2", model_rd(rn2, r_ev, wn, r_ew));
            #1;
            check(wb_data); check({31'b0, wb_valid}); check(rd1); check(rd2);
            @(posedge clk);
            if (r_ev) model[wn] = r_ew;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value from the MemtoReg, Jal, dmem read-data, ALU-result and PC fields, and commits it to a 32x32 general-purpose register file.
- Serves the two ID-stage source-operand reads, with same-cycle write-through bypass.
- Sits between the MEM/WB register and the ID stage; closes the writeback loop of the 5-stage pipeline.

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width
- NREGS, 32, number of architectural registers (2**ADDR_W)

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- RegWrite  in  1  writeback enable from MEM/WB
- MemtoReg  in  1  1: write dmem read data; 0: write ALU result
- Jal  in  1  1: write link PC (overrides MemtoReg)
- wn  in  ADDR_W  destination register index
- dmem_rdata  in  DATA_W  load data from MEM/WB
- alu_out  in  DATA_W  ALU result from MEM/WB
- pc  in  DATA_W  link value (already PC+4) from MEM/WB
- rn1  in  ADDR_W  source register index A (ID stage)
- rn2  in  ADDR_W  source register index B (ID stage)
- rd1  out  DATA_W  read data A
- rd2  out  DATA_W  read data B
- wb_data  out  DATA_W  selected writeback value, for EX forwarding
- wb_valid  out  1  RegWrite && wn != 0, for forwarding/hazard logic

Behaviour:
- wb_data is combinational:
  - Jal=1: pc
  - else MemtoReg=1: dmem_rdata
  - else: alu_out
- wb_valid is combinational: RegWrite && (wn != 0).
- Write: on posedge clk with rst=0 and wb_valid=1, regs[wn] <= wb_data. One-cycle latency to storage.
- Register 0:
  - never written; always reads 0.
  - A write with wn=0 is silently dropped; wb_valid=0 in that case.
- Reads are combinational:
  - rdX = 0 when rnX == 0.
  - Else rdX = wb_data when wb_valid && wn == rnX (write-through bypass, same cycle).
  - Else rdX = regs[rnX].
- rn1 == rn2 == wn with wb_valid: both outputs show wb_data.
- RegWrite=0: no state change, regardless of Jal/MemtoReg/wn values.
- Reset:
  - rst asserted at any time immediately clears all registers to 0, independent of clk.
  - While rst=1, writes are blocked and rd1/rd2 read 0 (no bypass).
  - wb_data and wb_valid stay combinational during reset and are not gated.
- Deassertion: the first write occurs on the first posedge with rst=0.
- Reset mid-writeback: the pending write is lost. No retry.
- No X propagation: every register has a defined reset value.
- Widths: no arithmetic; all data paths are DATA_W with no truncation.

Decomposition:
- Shared pipeline package holds:
  - DATA_W and ADDR_W
  - REG_ZERO = 0
  - REG_RA = 31
  - WB control bit positions (MemtoReg=2, RegWrite=1, Jal=0), matching the MEM/WB in_ctl encoding
- One sub-module: wb_mux (combinational 3:1 writeback select producing wb_data).
- Register array and bypass stay in wb_regfile.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, assert rst asynchronously between clock edges -> rd1 (rn1=5) reads 0 immediately, before the next posedge.
- ALU writeback: RegWrite=1, MemtoReg=0, Jal=0, wn=8, alu_out=0x00000123 -> same-cycle rd1 (rn1=8) = 0x123 via bypass; after posedge, with RegWrite=0, rd1 still = 0x123.
- Load vs link priority:
  - MemtoReg=1, dmem_rdata=0xCAFEF00D, wn=9 -> r9=0xCAFEF00D.
  - Then Jal=1, MemtoReg=1, pc=0x00400008, wn=31 -> r31=0x00400008 (Jal wins).
- r0 protection: RegWrite=1, wn=0, alu_out=0xFFFFFFFF -> wb_valid=0; rd1 (rn1=0) = 0 before and after posedge.
- Dual-port bypass: rn1=rn2=wn=12, RegWrite=1, alu_out=0xA5A5A5A5, r12 previously 0x11 -> rd1=rd2=0xA5A5A5A5 same cycle.
- Write disabled: RegWrite=0, wn=4, alu_out=0x77 over 3 posedges -> r4 unchanged (0); wb_valid=0 throughout.
